// File: rtl/hazard_scheduler.sv
// Hazard and sequencing controller for a five-stage core with branches resolved in ID.
// Tracks destination tags of EX/MEM/WB and drives stall, flush, forwarding and dmem_req.
module hazard_scheduler #(
    parameter int RFIDX_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [RFIDX_WIDTH-1:0] id_rs1,
    input  logic [RFIDX_WIDTH-1:0] id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [RFIDX_WIDTH-1:0] id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memtoreg,
    input  logic                   id_memwrite,
    input  logic                   id_branch,
    input  logic                   id_pcsrc,
    input  logic                   dmem_ready,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   stall_e,
    output logic                   stall_m,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic                   flush_w,
    output logic [1:0]             fwd_id_a,
    output logic [1:0]             fwd_id_b,
    output logic [1:0]             fwd_ex_a,
    output logic [1:0]             fwd_ex_b,
    output logic                   dmem_req,
    output logic [CNT_WIDTH-1:0]   stall_cycles
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // Shadow pipeline
    logic                   ex_valid;
    logic [RFIDX_WIDTH-1:0] ex_rd;
    logic [RFIDX_WIDTH-1:0] ex_rs1;
    logic [RFIDX_WIDTH-1:0] ex_rs2;
    logic                   ex_rw;
    logic                   ex_ld;
    logic                   ex_st;

    logic                   mem_valid;
    logic [RFIDX_WIDTH-1:0] mem_rd;
    logic                   mem_rw;
    logic                   mem_ld;
    logic                   mem_st;

    logic                   wb_valid;
    logic [RFIDX_WIDTH-1:0] wb_rd;
    logic                   wb_rw;

    // A stage produces a usable value for src; x0 is never a real destination.
    function automatic logic writer_hit(
        input logic                   valid,
        input logic                   rw,
        input logic [RFIDX_WIDTH-1:0] rd,
        input logic [RFIDX_WIDTH-1:0] src
    );
        return valid && rw && (rd == src) && (rd != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    logic use_a;
    logic use_b;
    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic ex_dep;
    logic mem_ld_dep;

    assign use_a     = id_valid && id_use_rs1;
    assign use_b     = id_valid && id_use_rs2;
    assign ex_hit_a  = writer_hit(ex_valid, ex_rw, ex_rd, id_rs1);
    assign ex_hit_b  = writer_hit(ex_valid, ex_rw, ex_rd, id_rs2);
    assign mem_hit_a = writer_hit(mem_valid, mem_rw, mem_rd, id_rs1);
    assign mem_hit_b = writer_hit(mem_valid, mem_rw, mem_rd, id_rs2);

    assign ex_dep     = (use_a && ex_hit_a) || (use_b && ex_hit_b);
    assign mem_ld_dep = mem_ld && ((use_a && mem_hit_a) || (use_b && mem_hit_b));

    // Hazard decisions in strict priority: memory wait, load-use, branch-data, redirect.
    logic mem_busy;
    logic mem_wait;
    logic load_use;
    logic branch_data;
    logic bubble;
    logic redirect;

    assign mem_busy    = mem_valid && (mem_ld || mem_st);
    assign mem_wait    = mem_busy && !dmem_ready;
    assign load_use    = !mem_wait && ex_ld && ex_dep;
    assign branch_data = !mem_wait && !load_use && id_valid && id_branch && (ex_dep || mem_ld_dep);
    assign bubble      = load_use || branch_data;
    assign redirect    = !mem_wait && !bubble && id_valid && id_pcsrc;

    // Forwarding candidates; a load in MEM has no result yet, so only WB can supply it.
    logic mem_fwd_id_a;
    logic mem_fwd_id_b;
    logic mem_fwd_ex_a;
    logic mem_fwd_ex_b;
    logic wb_fwd_id_a;
    logic wb_fwd_id_b;
    logic wb_fwd_ex_a;
    logic wb_fwd_ex_b;

    assign mem_fwd_id_a = mem_hit_a && !mem_ld;
    assign mem_fwd_id_b = mem_hit_b && !mem_ld;
    assign mem_fwd_ex_a = writer_hit(mem_valid, mem_rw, mem_rd, ex_rs1) && !mem_ld;
    assign mem_fwd_ex_b = writer_hit(mem_valid, mem_rw, mem_rd, ex_rs2) && !mem_ld;
    assign wb_fwd_id_a  = writer_hit(wb_valid, wb_rw, wb_rd, id_rs1);
    assign wb_fwd_id_b  = writer_hit(wb_valid, wb_rw, wb_rd, id_rs2);
    assign wb_fwd_ex_a  = writer_hit(wb_valid, wb_rw, wb_rd, ex_rs1);
    assign wb_fwd_ex_b  = writer_hit(wb_valid, wb_rw, wb_rd, ex_rs2);

    // Outputs are forced quiet while reset is asserted, even if ID inputs are live.
    logic run;
    assign run = reset;

    always_comb begin
        stall_f  = run && (mem_wait || bubble);
        stall_d  = run && (mem_wait || bubble);
        stall_e  = run && mem_wait;
        stall_m  = run && mem_wait;
        flush_d  = run && redirect;
        flush_e  = run && bubble;
        flush_w  = run && mem_wait;
        dmem_req = run && mem_busy;
        fwd_id_a = FWD_NONE;
        fwd_id_b = FWD_NONE;
        fwd_ex_a = FWD_NONE;
        fwd_ex_b = FWD_NONE;
        if (run) begin
            fwd_id_a = fwd_sel(mem_fwd_id_a, wb_fwd_id_a);
            fwd_id_b = fwd_sel(mem_fwd_id_b, wb_fwd_id_b);
            fwd_ex_a = fwd_sel(mem_fwd_ex_a, wb_fwd_ex_a);
            fwd_ex_b = fwd_sel(mem_fwd_ex_b, wb_fwd_ex_b);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rw     <= 1'b0;
            ex_ld     <= 1'b0;
            ex_st     <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_rw    <= 1'b0;
            mem_ld    <= 1'b0;
            mem_st    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_rw     <= 1'b0;
        end else if (mem_wait) begin
            // EX and MEM freeze; the WB slot drains as a bubble.
            wb_valid <= 1'b0;
        end else begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_rw     <= mem_rw;
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_rw    <= ex_rw;
            mem_ld    <= ex_ld;
            mem_st    <= ex_st;
            if (bubble) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid <= id_valid;
                ex_rd    <= id_rd;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rw    <= id_regwrite;
                ex_ld    <= id_memtoreg;
                ex_st    <= id_memwrite;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall_d && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: load-use, forwarding, branch stalls,
// redirect masking, memory wait and asynchronous reset.
module tb_hazard_scheduler;

    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memtoreg;
    logic          id_memwrite;
    logic          id_branch;
    logic          id_pcsrc;
    logic          dmem_ready;
    logic          stall_f;
    logic          stall_d;
    logic          stall_e;
    logic          stall_m;
    logic          flush_d;
    logic          flush_e;
    logic          flush_w;
    logic [1:0]    fwd_id_a;
    logic [1:0]    fwd_id_b;
    logic [1:0]    fwd_ex_a;
    logic [1:0]    fwd_ex_b;
    logic          dmem_req;
    logic [CW-1:0] stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_scheduler #(.RFIDX_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memtoreg  (id_memtoreg),
        .id_memwrite  (id_memwrite),
        .id_branch    (id_branch),
        .id_pcsrc     (id_pcsrc),
        .dmem_ready   (dmem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .fwd_id_a     (fwd_id_a),
        .fwd_id_b     (fwd_id_b),
        .fwd_ex_a     (fwd_ex_a),
        .fwd_ex_b     (fwd_ex_b),
        .dmem_req     (dmem_req),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Control bundle order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w
    task automatic chk_ctl(input string tag, input logic [6:0] exp_v);
        chk(tag, {25'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, {25'd0, exp_v});
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                          input int rd, input logic rw, input logic ld, input logic st,
                          input logic br, input logic pc);
        id_valid    = v;
        id_rs1      = RW'(rs1);
        id_rs2      = RW'(rs2);
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = RW'(rd);
        id_regwrite = rw;
        id_memtoreg = ld;
        id_memwrite = st;
        id_branch   = br;
        id_pcsrc    = pc;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        dmem_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b0;
        dmem_ready = 1'b1;
        // Live redirect request while in reset must not leak to flush_d.
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk_ctl("reset_ctl", 7'b0000000);
        chk("reset_dmem_req", dmem_req, 0);
        chk("reset_fwd", {fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b}, 0);
        chk("reset_cnt", stall_cycles, 0);
        idle();
        reset = 1'b1;
        tick();

        // Load-use: lw x5,0(x2) ; add x6,x5,x1
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk_ctl("lu_lw_issue", 7'b0000000);
        tick();
        set_id(1'b1, 5, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk_ctl("lu_stall", 7'b1100010);
        tick();
        settle();
        chk_ctl("lu_release", 7'b0000000);
        chk("lu_dmem_req", dmem_req, 1);
        chk("lu_cnt", stall_cycles, 1);
        tick();
        idle();
        settle();
        chk("lu_fwd_ex_a", fwd_ex_a, 2'b10);
        chk("lu_fwd_ex_b", fwd_ex_b, 2'b00);
        drain();

        // ALU forwarding: add x3 ; sub x4,x3,x3
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk_ctl("alu_no_stall", 7'b0000000);
        tick();
        idle();
        settle();
        chk("alu_fwd_mem", {fwd_ex_a, fwd_ex_b}, 4'b0101);
        drain();

        // One independent instruction in between: add x3 ; or x8,x9,x10 ; sub x4,x3,x3
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 9, 10, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // add x0,x1,x2 enters ID while sub sits in EX
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("alu_fwd_wb", {fwd_ex_a, fwd_ex_b}, 4'b1010);
        tick();
        // sub x4,x0,x0 must never pick up the x0 write
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        chk("alu_fwd_x0", {fwd_ex_a, fwd_ex_b}, 4'b0000);
        drain();

        // Branch after load: lw x7 ; beq x7,x0 (taken)
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 7, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk_ctl("bl_stall1", 7'b1100010);
        tick();
        settle();
        chk_ctl("bl_stall2", 7'b1100010);
        chk("bl_dmem_req", dmem_req, 1);
        tick();
        settle();
        chk_ctl("bl_redirect", 7'b0000100);
        chk("bl_fwd_id", {fwd_id_a, fwd_id_b}, 4'b1000);
        chk("bl_cnt", stall_cycles, 3);
        tick();
        drain();

        // ALU to branch with redirect requested during the stall: add x9 ; bne x9,x1
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 9, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk_ctl("rd_stall_masks_pcsrc", 7'b1100010);
        tick();
        settle();
        chk_ctl("rd_redirect", 7'b0000100);
        chk("rd_fwd_id", {fwd_id_a, fwd_id_b}, 4'b0100);
        chk("rd_cnt", stall_cycles, 4);
        tick();
        drain();

        // Memory wait: sw in MEM with dmem_ready low for 3 cycles
        set_id(1'b1, 2, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctl($sformatf("mw_wait%0d", i), 7'b1111001);
            chk($sformatf("mw_req%0d", i), dmem_req, 1);
            tick();
        end
        dmem_ready = 1'b1;
        settle();
        chk_ctl("mw_complete", 7'b0000000);
        chk("mw_req_last", dmem_req, 1);
        chk("mw_cnt", stall_cycles, 7);
        tick();
        settle();
        chk("mw_req_gone", dmem_req, 0);
        drain();

        // Memory wait overlapping load-use: lw x12 ; lw x10 ; add x13,x10,x0
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 2, 0, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk_ctl("ov_no_dep", 7'b0000000);
        tick();
        set_id(1'b1, 10, 0, 1'b1, 1'b1, 13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        settle();
        chk_ctl("ov_wait_wins", 7'b1111001);
        tick();
        dmem_ready = 1'b1;
        settle();
        chk_ctl("ov_load_use_after", 7'b1100010);
        tick();
        settle();
        chk_ctl("ov_release", 7'b0000000);
        chk("ov_cnt", stall_cycles, 9);
        tick();
        drain();

        // Asynchronous reset in the middle of a memory wait
        set_id(1'b1, 2, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        dmem_ready = 1'b0;
        settle();
        chk_ctl("ar_wait", 7'b1111001);
        chk("ar_cnt_before", stall_cycles, 9);
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_ctl("ar_ctl_now", 7'b0000000);
        chk("ar_req_now", dmem_req, 0);
        chk("ar_cnt_now", stall_cycles, 0);
        tick();
        tick();
        idle();
        settle();
        reset = 1'b1;
        tick();
        settle();
        chk_ctl("ar_post_ctl", 7'b0000000);
        chk("ar_post_req", dmem_req, 0);
        tick();
        settle();
        chk_ctl("ar_post_ctl2", 7'b0000000);
        chk("ar_post_cnt", stall_cycles, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard and sequencing controller for the xgRISCV five-stage core (IF/ID/EX/MEM/WB, branches resolved in ID). It keeps a shadow pipeline of destination tags for EX, MEM and WB and compares them against the instruction now in decode. From that it drives stall, flush and forwarding selects, plus the data-memory request handshake. It sits beside the decode-stage controller, which supplies the ID-stage decode fields.

## Interface
Parameters:
- RFIDX_WIDTH, 5, register index width
- CNT_WIDTH, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RFIDX_WIDTH  ID source indices
- id_use_rs1, id_use_rs2  in  1  ID instruction reads that source
- id_rd  in  RFIDX_WIDTH  ID destination
- id_regwrite, id_memtoreg, id_memwrite  in  1  ID writes rd / is load / is store
- id_branch  in  1  ID uses the decode-stage comparator (branch or jalr)
- id_pcsrc  in  1  ID requests PC redirect this cycle
- dmem_ready  in  1  data memory completes the MEM access this cycle
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC / IF-ID / ID-EX / EX-MEM registers
- flush_d, flush_e, flush_w  out  1  load bubble into IF-ID / ID-EX / MEM-WB
- fwd_id_a, fwd_id_b  out  2  ID comparator source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result
- fwd_ex_a, fwd_ex_b  out  2  ALU operand source: 00 ID/EX value, 01 EX/MEM ALU result, 10 MEM/WB result
- dmem_req  out  1  MEM stage holds a load/store awaiting completion
- stall_cycles  out  CNT_WIDTH  count of cycles with stall_d=1, saturating

## Operation
- Shadow state per stage: EX {valid, rd, rs1, rs2, rw, ld, st}, MEM {valid, rd, rw, ld, st}, WB {valid, rd, rw}.
- A writer matches source s when its stage is valid, rw=1, rd==s and rd!=0. x0 never matches.
- Hazards are evaluated in this priority order:
  1. **Memory wait:** MEM valid, (ld|st)=1 and dmem_ready=0.
     - Assert stall_f, stall_d, stall_e, stall_m and flush_w.
     - Shadow EX/MEM hold; shadow WB becomes invalid.
  2. **Load-use:** the EX writer is a load and matches a used ID source.
     - Assert stall_f, stall_d and flush_e.
     - Shadow EX becomes invalid; MEM and WB advance.
  3. **Branch-data:** id_branch=1 and a used source is matched by the EX writer (any kind) or by a MEM load.
     - Same response as load-use.
  4. **Redirect:** id_valid and id_pcsrc with no stall from rules 1-3.
     - Assert flush_d.
     - id_pcsrc is ignored in any stalled cycle; ID re-evaluates next cycle.
  5. **Otherwise:** all stall/flush outputs are 0.
     - WB<=MEM, MEM<=EX, EX<=ID fields; EX.valid=id_valid.
- fwd_id_x (ID comparator source):
  - 01 if the MEM non-load writer matches the source.
  - Else 10 if the WB writer matches.
  - Else 00.
- fwd_ex_x (ALU operand, uses EX.rs1/EX.rs2):
  - 01 if the MEM non-load writer matches.
  - Else 10 if the WB writer matches.
  - Else 00.
  - MEM has priority over WB (youngest result wins).
- dmem_req = MEM.valid & (MEM.ld | MEM.st). It stays high until the cycle dmem_ready=1, then the instruction advances.
- stall_cycles increments on every rising edge where stall_d=1, and saturates at all-ones.

## Timing
- All stall/flush/fwd/dmem_req outputs are combinational from shadow state, ID inputs and dmem_ready; they act in the same cycle.
- Shadow state and the counter update on the rising clk edge.
- Load-use and branch-data cost exactly 1 stall cycle per dependent producer-stage gap:
  - load to dependent ALU op: 1 stall;
  - ALU to dependent branch: 1 stall;
  - load to dependent branch: 2 stalls.
- Memory wait lasts N cycles for N cycles of dmem_ready=0. The instruction completes on the first cycle with dmem_ready=1.
- Memory wait concurrent with load-use: memory wait wins. The load-use bubble is inserted in the first cycle after memory resumes, if the dependence still holds.
- Reset (asynchronous, any cycle, including mid-stall):
  - all shadow valids and the counter clear to 0;
  - all outputs 0; fwd selects 00; dmem_req 0.
  - First evaluation happens on the first edge after reset is released.

## Test plan
- **Load-use:** lw x5 then add x6,x5,x1.
  - Expect exactly one cycle of stall_f=stall_d=flush_e=1.
  - Then fwd_ex_a=10 for add; stall_cycles=1.
- **ALU forwarding:** add x3,.. ; sub x4,x3,x3.
  - Expect no stall, fwd_ex_a=fwd_ex_b=01.
  - With one independent instruction between them, fwd=10.
  - With rd=x0, fwd=00.
- **Branch after load:** lw x7 ; beq x7,x0.
  - Expect 2 stall cycles, then fwd_id_a=10 and flush_d=1 if id_pcsrc=1.
- **Memory wait:** sw in MEM with dmem_ready low for 3 cycles.
  - Expect dmem_req=1 and stall_f/d/e/m=flush_w=1 for 3 cycles.
  - Advance on cycle 4; stall_cycles=3.
- **Redirect while stalled:** id_pcsrc=1 during a branch-data stall.
  - Expect flush_d=0 during the stall, then flush_d=1 in the first unstalled cycle.
- **Async reset:** assert reset low mid memory-wait.
  - Outputs go 0 immediately, and stall_cycles=0.
  - After release with id_valid=0, no stalls occur.
